pc_fetch_unit: RTL and testbench

- Instruction-fetch stage for the 14-bit MCU core. Sits directly upstream of Program_Rom.
- Holds the program counter and drives the ROM address. Latches the returned word into the instruction register (IR) for decode/execute.
- Owns the 8-level hardware call/return stack.
- Implements next-PC selection (increment, jump/call, return) and pipeline flush for taken branches and skips.

---
 rtl/mcu_pkg.sv | 18 +
 rtl/pc_fetch_unit_return_stack.sv | 60 ++++++
 rtl/pc_fetch_unit.sv | 95 +++++++++
 tb/tb_pc_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants and types for the 14-bit MCU core.
// Address/data widths, the flush word and the next-PC select encoding.
package mcu_pkg;

    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 14;
    localparam int STACK_DEPTH = 8;

    localparam logic [DATA_W-1:0] NOP_WORD = 14'h0000;

    // 2'b11 is deliberately not named: the fetch unit treats it as PC_INC.
    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_JMP = 2'b01,
        PC_RET = 2'b10
    } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_return_stack.sv
// Circular hardware call/return stack. A push when full overwrites the oldest
// entry; a pop when empty still wraps. Both raise a one-cycle err pulse.
module return_stack
    import mcu_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          err
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = SP_W + 1;

    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    logic [AW-1:0]    mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_prev;
    logic [CNT_W-1:0] count;

    // sp is exactly log2(DEPTH) bits, so +1/-1 wrap the circular buffer for free.
    assign sp_prev = sp - SP_ONE;
    assign top     = mem[sp_prev];
    assign err     = (push && (count == FULL)) || (pop && (count == '0));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            // NOTE: the stack array is cleared on reset because a RETURN on an
            // empty stack is architecturally visible and must yield address 0.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + SP_ONE;
            if (count != FULL) begin
                count <= count + CNT_ONE;
            end
        end else if (pop) begin
            sp <= sp_prev;
            if (count != '0) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register, next-PC
// selection with branch/skip flush, and the call/return stack.
module pc_fetch_unit #(
    parameter int                           ADDR_W      = mcu_pkg::ADDR_W,
    parameter int                           DATA_W      = mcu_pkg::DATA_W,
    parameter int                           STACK_DEPTH = mcu_pkg::STACK_DEPTH,
    parameter logic [mcu_pkg::DATA_W-1:0]   NOP_WORD    = mcu_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic              stall,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              push,
    input  logic              skip,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic              stack_err
);

    import mcu_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ret_addr;
    logic [DATA_W-1:0] ir;
    logic              ir_valid_q;
    logic              stack_err_q;
    logic              flush;
    logic              do_push;
    logic              do_pop;
    logic              stack_fault;

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        next_pc = pc + PC_ONE;
        flush   = skip;
        do_push = 1'b0;
        do_pop  = 1'b0;
        case (pc_sel)
            PC_JMP: begin
                next_pc = jump_target;
                flush   = 1'b1;
                do_push = push && !stall;
            end
            PC_RET: begin
                next_pc = ret_addr;
                flush   = 1'b1;
                do_pop  = !stall;
            end
            default: ;
        endcase
    end

    // pc has already advanced past the CALL, so it is the return address.
    return_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (ADDR_W)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc),
        .top       (ret_addr),
        .err       (stack_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            ir          <= NOP_WORD;
            ir_valid_q  <= 1'b0;
            stack_err_q <= 1'b0;
        end else if (!stall) begin
            pc         <= next_pc;
            ir         <= flush ? NOP_WORD : rom_data_in;
            ir_valid_q <= !flush;
            if (stack_fault) begin
                stack_err_q <= 1'b1;
            end
        end
    end

    assign rom_addr_out = pc;
    assign ir_out       = ir;
    assign ir_valid     = ir_valid_q;
    assign stack_err    = stack_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a directed vector table from reset,
// then hand-written stack overflow and mid-operation reset sequences.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] rom_data_in;
    logic [10:0] rom_addr_out;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [10:0] jump_target;
    logic        push;
    logic        skip;
    logic [13:0] ir_out;
    logic        ir_valid;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    logic [13:0] rom [2048];

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rom_data_in  (rom_data_in),
        .rom_addr_out (rom_addr_out),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .jump_target  (jump_target),
        .push         (push),
        .skip         (skip),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    assign rom_data_in = rom[rom_addr_out];

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic [10:0] tgt;
        logic        push;
        logic        skip;
        logic [10:0] pc;
        logic [13:0] ir;
        logic        valid;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic [10:0] tgt,
                         input logic ps, input logic sk, input logic rs);
        stall       = st;
        pc_sel      = sel;
        jump_target = tgt;
        push        = ps;
        skip        = sk;
        rst         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [10:0] pc, input logic [13:0] ir,
                                input logic valid, input logic err);
        check({tag, " pc"}, 32'(rom_addr_out), 32'(pc));
        check({tag, " ir"}, 32'(ir_out), 32'(ir));
        check({tag, " valid"}, 32'(ir_valid), 32'(valid));
        check({tag, " err"}, 32'(stack_err), 32'(err));
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic [10:0] tgt,
                                input logic ps, input logic sk, input logic [10:0] pc,
                                input logic [13:0] ir, input logic valid);
        vec_t v;
        v.stall = st; v.sel = sel; v.tgt = tgt; v.push = ps; v.skip = sk;
        v.pc = pc; v.ir = ir; v.valid = valid;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 14'h2000 | 14'(i);
        rom[0]      = 14'h01A5;
        rom[1]      = 14'h0103;
        rom[2]      = 14'h3028;
        rom[3]      = 14'h00A5;
        rom[5]      = 14'h0D25;
        rom[11'h0A] = 14'h280A;

        //              stall sel    tgt      push skip  pc       ir        valid
        vecs[0]  = mk(0, 2'b00, 11'h000, 0, 0, 11'h001, 14'h01A5, 1);
        vecs[1]  = mk(0, 2'b00, 11'h000, 0, 0, 11'h002, 14'h0103, 1);
        vecs[2]  = mk(0, 2'b00, 11'h000, 0, 0, 11'h003, 14'h3028, 1);
        vecs[3]  = mk(0, 2'b00, 11'h000, 0, 0, 11'h004, 14'h00A5, 1);
        vecs[4]  = mk(1, 2'b00, 11'h000, 0, 0, 11'h004, 14'h00A5, 1);
        vecs[5]  = mk(1, 2'b01, 11'h123, 1, 1, 11'h004, 14'h00A5, 1);
        vecs[6]  = mk(1, 2'b10, 11'h000, 0, 0, 11'h004, 14'h00A5, 1);
        vecs[7]  = mk(0, 2'b00, 11'h000, 0, 1, 11'h005, 14'h0000, 0);
        vecs[8]  = mk(0, 2'b00, 11'h000, 0, 0, 11'h006, 14'h0D25, 1);
        vecs[9]  = mk(0, 2'b01, 11'h00A, 0, 0, 11'h00A, 14'h0000, 0);
        vecs[10] = mk(0, 2'b00, 11'h000, 0, 0, 11'h00B, 14'h280A, 1);
        vecs[11] = mk(0, 2'b01, 11'h00A, 0, 0, 11'h00A, 14'h0000, 0);
        vecs[12] = mk(0, 2'b00, 11'h000, 0, 0, 11'h00B, 14'h280A, 1);
        vecs[13] = mk(0, 2'b01, 11'h00A, 0, 0, 11'h00A, 14'h0000, 0);
        vecs[14] = mk(0, 2'b00, 11'h000, 0, 0, 11'h00B, 14'h280A, 1);
        vecs[15] = mk(0, 2'b01, 11'h005, 0, 0, 11'h005, 14'h0000, 0);
        vecs[16] = mk(0, 2'b01, 11'h100, 1, 0, 11'h100, 14'h0000, 0);
        vecs[17] = mk(0, 2'b00, 11'h000, 0, 0, 11'h101, 14'h2100, 1);
        vecs[18] = mk(0, 2'b00, 11'h000, 0, 0, 11'h102, 14'h2101, 1);
        vecs[19] = mk(0, 2'b00, 11'h000, 0, 0, 11'h103, 14'h2102, 1);
        vecs[20] = mk(0, 2'b10, 11'h000, 0, 0, 11'h005, 14'h0000, 0);
        vecs[21] = mk(0, 2'b00, 11'h000, 0, 0, 11'h006, 14'h0D25, 1);
        vecs[22] = mk(0, 2'b00, 11'h000, 1, 0, 11'h007, 14'h2006, 1);
        vecs[23] = mk(0, 2'b01, 11'h7FF, 0, 1, 11'h7FF, 14'h0000, 0);
        vecs[24] = mk(0, 2'b00, 11'h000, 0, 0, 11'h000, 14'h27FF, 1);
        vecs[25] = mk(0, 2'b00, 11'h000, 0, 0, 11'h001, 14'h01A5, 1);
        vecs[26] = mk(0, 2'b11, 11'h000, 0, 0, 11'h002, 14'h0103, 1);

        stall = 1'b0; pc_sel = 2'b00; jump_target = '0; push = 1'b0; skip = 1'b0; rst = 1'b1;
        do_reset();
        expect_state("reset", 11'h000, 14'h0000, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].sel, vecs[i].tgt, vecs[i].push, vecs[i].skip, 1'b0);
            expect_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ir, vecs[i].valid, 1'b0);
        end

        // Nine consecutive CALLs: the first return address (0x000) is overwritten.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 2'b01, 11'h010 + 11'(i), 1'b1, 1'b0, 1'b0);
            check($sformatf("ovf call%0d pc", i), 32'(rom_addr_out), 32'(11'h010 + 11'(i)));
            check($sformatf("ovf call%0d err", i), 32'(stack_err), (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b10, 11'h000, 1'b0, 1'b0, 1'b0);
            check($sformatf("ovf ret%0d pc", i), 32'(rom_addr_out), 32'(11'h017 - 11'(i)));
            check($sformatf("ovf ret%0d valid", i), 32'(ir_valid), 32'd0);
        end
        check("ovf err sticky", 32'(stack_err), 32'd1);

        // Fill the stack, unwind to count=3, then reset while stalled.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b0, 2'b01, 11'h020 + 11'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b10, 11'h000, 1'b0, 1'b0, 1'b0);
            check($sformatf("unwind%0d pc", i), 32'(rom_addr_out), 32'(11'h026 - 11'(i)));
        end
        drive(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
        check("pre-rst valid", 32'(ir_valid), 32'd1);
        drive(1'b1, 2'b01, 11'h055, 1'b1, 1'b0, 1'b1);
        expect_state("mid rst", 11'h000, 14'h0000, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 11'h000, 1'b0, 1'b0, 1'b0);
        expect_state("ret empty", 11'h000, 14'h0000, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
        expect_state("err sticky", 11'h001, 14'h01A5, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
